// File: rtl/ebr_stream_reader.sv
// Streams a contiguous block of EBR words out over a valid/ready interface,
// buffering read data in a 2-entry first-word-fall-through FIFO.
module ebr_stream_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic              r_inflight, r_inflight_last;
  logic [DATA_W-1:0] r_fdata [2];
  logic [1:0]        r_flast;
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;

  logic [1:0] w_occ;
  logic       w_head_vld, w_valid, w_pop, w_issue, w_bypass, w_store, w_deq, w_last_rd;

  // Occupancy counts words held plus the one read whose data lands this cycle.
  assign w_occ      = r_count + {1'b0, r_inflight};
  assign w_head_vld = (r_count != 2'd0);
  assign w_valid    = w_head_vld | r_inflight;
  assign w_pop      = w_valid & m_ready;
  assign w_last_rd  = (r_remain == (ADDR_W+1)'(1));
  assign w_issue    = (r_state == S_READ) && (r_remain != '0) &&
                      ((w_occ < 2'd2) || w_pop);
  // Incoming word goes straight out when nothing is queued ahead of it.
  assign w_bypass   = r_inflight & ~w_head_vld & w_pop;
  assign w_store    = r_inflight & ~w_bypass;
  assign w_deq      = w_pop & w_head_vld;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (length == '0) ? S_DONE : S_READ;
      S_READ:  if (w_issue && w_last_rd) w_state_nxt = S_DRAIN;
      // Leave once the final word is leaving this cycle, so done follows the m_last beat.
      S_DRAIN: if ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fdata[0]      <= '0;
      r_fdata[1]      <= '0;
      r_flast         <= '0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_addr   <= base_addr;
        r_remain <= length;
      end else if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_last_rd;
      if (w_store) begin
        r_fdata[r_wptr] <= ram_rdata;
        r_flast[r_wptr] <= r_inflight_last;
        r_wptr          <= ~r_wptr;
      end
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign ram_re    = w_issue;
  assign ram_raddr = r_addr;
  assign m_valid   = w_valid;
  assign m_data    = w_head_vld ? r_fdata[r_rptr] : (r_inflight ? ram_rdata : '0);
  assign m_last    = w_head_vld ? r_flast[r_rptr] : (r_inflight & r_inflight_last);

endmodule

// File: tb/tb_ebr_stream_reader.sv
// Scoreboard bench: expected words queued at start, compared as beats leave.
module tb_ebr_stream_reader;

  logic        clk = 1'b0;
  logic        resetn, start, busy, done, ram_re, m_valid, m_last, m_ready;
  logic [9:0]  base_addr, ram_raddr;
  logic [10:0] length;
  logic [15:0] ram_rdata, m_data;
  logic [15:0] mem [1024];

  logic [16:0] exp_q [$];
  int          addr_log [$];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  int          rd_cnt, beat_cnt, first_beat, last_beat, done_cyc;
  logic        stalled_prev = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [16:0] e;

  ebr_stream_reader #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_raddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) stalled_prev = 1'b0;
    else begin
      if (stalled_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (ram_re) begin rd_cnt++; addr_log.push_back(ram_raddr); end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e[15:0]);
          chk("beat_last", m_last, e[16]);
        end
        beat_cnt++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
      end
      if (busy) chk("unread_le2", (rd_cnt - beat_cnt) <= 2, 1);
      if (done) begin done_cyc = cyc; chk("busy_at_done", busy, 1); end
      stalled_prev = m_valid && !m_ready;
      prev_data    = m_data;
      prev_last    = m_last;
    end
  end

  task automatic clr_counts();
    rd_cnt = 0; beat_cnt = 0; first_beat = -1; last_beat = -1; done_cyc = -1;
    addr_log.delete();
  endtask

  task automatic run_xfer(input int base, input int len, input int mode);
    int t0, j;
    for (int k = 0; k < len; k++) exp_q.push_back({(k == len-1), mem[(base+k)%1024]});
    clr_counts();
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'(base); length = 11'(len); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    j = 1;
    while (done_cyc < 0 && j < 3000) begin
      m_ready = (mode == 0) ? 1'b1 : ((j >= 8 && j < 13) ? 1'b0 : (j % 2 == 0));
      @(posedge clk); #1;
      j++;
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_lat", done_cyc - ((len == 0) ? t0 : last_beat), 1);
    chk("reads", rd_cnt, len);
    chk("beats", beat_cnt, len);
    for (int k = 0; k < addr_log.size(); k++) chk("raddr", addr_log[k], (base+k)%1024);
    if (len > 0 && mode == 0) begin
      chk("first_lat", first_beat - t0, 2);
      chk("no_gaps", last_beat - first_beat, len-1);
    end
    chk("q_empty", exp_q.size(), 0);
    exp_q.delete();
    m_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    resetn = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    clr_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_re", ram_re, 0);   chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0); chk("rst_raddr", ram_raddr, 0);
    chk("rst_data", m_data, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    mem[5] = 16'hA5A5;
    run_xfer(5, 1, 0);
    mem[5] = 16'd5;
    run_xfer(0, 8, 0);
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 16'h1234);
    run_xfer(40, 16, 1);
    run_xfer(1022, 4, 0);
    run_xfer(7, 0, 0);

    // Ignored start during READ, then reset mid-transfer.
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), mem[200+k]});
    clr_counts();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd200; length = 11'd16;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd100; length = 11'd2;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    while (beat_cnt < 3 && j < 50) begin @(posedge clk); #1; j++; end
    chk("beats_before_rst", beat_cnt, 3);
    resetn = 1'b0;
    #1;
    chk("mid_busy", busy, 0);   chk("mid_done", done, 0);
    chk("mid_re", ram_re, 0);   chk("mid_valid", m_valid, 0);
    chk("mid_last", m_last, 0); chk("mid_raddr", ram_raddr, 0);
    chk("mid_data", m_data, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cyc, -1);
    chk("no_beats_after_rst", beat_cnt, 3);
    run_xfer(300, 6, 0);

    run_xfer(1000, 1024, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
